// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Bundles the M-stage request/response signals and the data
//                memory bus of the memory access unit.
//                slave  - view taken by mem_access_unit
//                master - view taken by the pipeline / memory environment
//  Ports       : memread_m, memwrite_m, size_m, unsigned_m, aluout_m,
//                writedata_m  (pipeline -> unit)
//                readdata_m, stall_m, misalign_m (unit -> pipeline)
//                dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
//                (unit -> memory)
//                dmem_rdata, dmem_ack (memory -> unit)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;
  logic        memread_m;
  logic        memwrite_m;
  logic [1:0]  size_m;
  logic        unsigned_m;
  logic [31:0] aluout_m;
  logic [31:0] writedata_m;
  logic [31:0] readdata_m;
  logic        stall_m;
  logic        misalign_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport slave (
    input  memread_m, memwrite_m, size_m, unsigned_m, aluout_m, writedata_m,
    input  dmem_rdata, dmem_ack,
    output readdata_m, stall_m, misalign_m,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport master (
    output memread_m, memwrite_m, size_m, unsigned_m, aluout_m, writedata_m,
    output dmem_rdata, dmem_ack,
    input  readdata_m, stall_m, misalign_m,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : M-stage load/store unit. Checks alignment, issues a single
//                data memory request per instruction, stalls the pipeline
//                until the memory acknowledges, and aligns/extends load data.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous, active-low reset
//                bus    - mem_access_unit_if.slave (pipeline + memory bus)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_unit_if.slave     bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] readdata_q;

  logic        access;
  logic        misalign;
  logic        start;
  logic        stall;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_d;

  assign access = bus.memread_m | bus.memwrite_m;

  // Size 11 behaves as a word everywhere, so size_m[1] means "word".
  assign misalign = (state_q == IDLE) & access &
                    (((bus.size_m == SZ_HALF) & bus.aluout_m[0]) |
                     (bus.size_m[1] & (bus.aluout_m[1:0] != 2'b00)));

  assign start = (state_q == IDLE) & access & ~misalign;

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.writedata_m;
    case (bus.size_m)
      SZ_BYTE: begin
        be_d    = 4'b0001 << bus.aluout_m[1:0];
        wdata_d = {4{bus.writedata_m[7:0]}};
      end
      SZ_HALF: begin
        be_d    = bus.aluout_m[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{bus.writedata_m[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = bus.writedata_m;
      end
    endcase
  end

  // Load lane selection and extension, driven by the registered request
  always_comb begin
    byte_lane = bus.dmem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    byte_lane = bus.dmem_rdata[7:0];
      2'd1:    byte_lane = bus.dmem_rdata[15:8];
      2'd2:    byte_lane = bus.dmem_rdata[23:16];
      default: byte_lane = bus.dmem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    load_d = bus.dmem_rdata;
    case (size_q)
      SZ_BYTE: load_d = unsigned_q ? {24'd0, byte_lane}
                                   : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_d = unsigned_q ? {16'd0, half_lane}
                                   : {{16{half_lane[15]}}, half_lane};
      default: load_d = bus.dmem_rdata;
    endcase
  end

  // DONE always falls back to IDLE so a held request is not replayed.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) state_d = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.dmem_ack) state_d = DONE;
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q     <= bus.aluout_m;
        we_q       <= bus.memwrite_m;   // store wins when both are set
        be_q       <= be_d;
        wdata_q    <= wdata_d;
        size_q     <= bus.size_m;
        unsigned_q <= bus.unsigned_m;
      end
      if ((state_q == BUSY) && bus.dmem_ack && !we_q) begin
        readdata_q <= load_d;
      end
    end
  end

  // Request is a pure decode of the state register, so an asynchronous
  // reset removes it immediately.
  assign bus.dmem_req   = (state_q == BUSY);
  assign bus.dmem_we    = (state_q == BUSY) & we_q;
  assign bus.dmem_addr  = {addr_q[31:2], 2'b00};
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.readdata_m = readdata_q;
  assign bus.stall_m    = stall;
  assign bus.misalign_m = misalign;

endmodule
`default_nettype wire
